imem_loader: RTL

//   Boot-time program loader and the write-side counterpart of instruction_memory.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 47 ++++
 rtl/imem_loader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes into little-endian 32-bit words; o_word_valid pulses
// for one cycle, the cycle after lane 3 is accepted.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_clear,
  input  logic                      i_byte_en,
  input  logic [7:0]                i_byte,
  output logic                      o_word_valid,
  output logic [8*WORD_BYTES-1:0]   o_word
);

  logic [1:0]                    r_lane;
  logic [23:0]                   r_low;
  logic                          r_valid;
  logic [8*WORD_BYTES-1:0]       r_out;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_lane  <= '0;
      r_low   <= '0;
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      r_valid <= 1'b0;
      if (i_byte_en) begin
        r_lane <= r_lane + 2'd1;
        case (r_lane)
          2'd0: r_low[7:0]   <= i_byte;
          2'd1: r_low[15:8]  <= i_byte;
          2'd2: r_low[23:16] <= i_byte;
          default: begin
            // Separate output register keeps the word stable while lane 0 of the next word lands.
            r_out   <= {i_byte, r_low};
            r_valid <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_word_valid = r_valid;
  assign o_word       = r_out;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes packed words to
// sequential instruction-memory addresses and holds the CPU in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned                ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR  = '0,
  parameter int unsigned                MAX_WORDS  = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   imem_wr_en,
  output logic [ADDR_WIDTH-1:0]  imem_wr_addr,
  output logic [31:0]            imem_wr_data,
  output logic                   cpu_reset,
  output logic                   load_done,
  output logic                   load_error
);

  localparam logic [16:0] LP_MAX = 17'(MAX_WORDS);

  state_t                r_state, w_next;
  logic [15:0]           r_len;
  logic [15:0]           r_words;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic        w_accept;
  logic        w_clear;
  logic        w_byte_en;
  logic        w_word_valid;
  logic [31:0] w_word;
  logic [15:0] w_len_n;
  logic        w_last;

  assign w_accept  = in_valid && in_ready;
  assign w_byte_en = w_accept && (r_state == ST_DATA);
  assign w_len_n   = {in_data, r_len[7:0]};
  assign w_last    = (r_words + 16'd1) == r_len;

  byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_clear),
    .i_byte_en    (w_byte_en),
    .i_byte       (in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_words <= '0;
      r_addr  <= BASE_ADDR;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_words <= '0;
        r_addr  <= BASE_ADDR;
      end else if (w_word_valid) begin
        r_words <= r_words + 16'd1;
        r_addr  <= r_addr + ADDR_WIDTH'(WORD_BYTES);
      end
      if (w_accept && r_state == ST_LEN_LO) r_len[7:0]  <= in_data;
      if (w_accept && r_state == ST_LEN_HI) r_len[15:8] <= in_data;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    in_ready   = 1'b0;
    cpu_reset  = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next  = ST_LEN_LO;
          w_clear = 1'b1;
        end
      end
      ST_LEN_LO: begin
        in_ready = 1'b1;
        if (w_accept) w_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        in_ready = 1'b1;
        if (w_accept) begin
          if (w_len_n == 16'd0)              w_next = ST_DONE;
          else if ({1'b0, w_len_n} > LP_MAX) w_next = ST_ERROR;
          else                               w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        if (w_word_valid && w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        load_done = 1'b1;
        cpu_reset = 1'b0;
        if (start) begin
          w_next  = ST_LEN_LO;
          w_clear = 1'b1;
        end
      end
      ST_ERROR: begin
        load_error = 1'b1;
        if (start) begin
          w_next  = ST_LEN_LO;
          w_clear = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign imem_wr_en   = w_word_valid;
  assign imem_wr_addr = r_addr;
  assign imem_wr_data = w_word;

endmodule
